// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the green-LED PIO write arbiter.
package led_ctrl_pkg;

  // Controller phases: one-shot init write, arbitration, bus write, grant.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  // The PIO data register sits at offset 0 of the s1 slave.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Avalon-MM data bus width of the PIO slave.
  localparam int PIO_BUS_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan requesters starting at ptr; the first active one wins.
  always_comb begin
    found_s    = 1'b0;
    cand_s     = {IDX_W{1'b0}};
    winner     = {N{1'b0}};
    winner_idx = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = IDX_W'((int'(ptr) + i) % N);
      if (!found_s && req[cand_s]) begin
        found_s            = 1'b1;
        winner_idx         = cand_s;
        winner[cand_s]     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Shares the green-LED PIO write port among several requesters. Each grant
// merges the requester's owned bits into a shadow copy of the LED register
// and issues exactly one Avalon-MM write. INIT_PATTERN is written once after
// every reset so LEDs and shadow start in a known state.
module led_pio_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int                 NUM_REQ      = 2,
  parameter int                 DATA_W       = 9,
  parameter logic [DATA_W-1:0]  INIT_PATTERN = {DATA_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*DATA_W-1:0]   req_mask,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        busy,
  output logic [DATA_W-1:0]           led_shadow,
  output logic [1:0]                  pio_address,
  output logic                        pio_chipselect,
  output logic                        pio_write_n,
  output logic [PIO_BUS_W-1:0]        pio_writedata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_r, state_next_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_next_s;
  logic [IDX_W-1:0]     grant_idx_r, grant_idx_next_s;
  logic [NUM_REQ-1:0]   grant_oh_r, grant_oh_next_s;

  logic [NUM_REQ-1:0]   win_oh_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [DATA_W-1:0]    win_data_s;
  logic [DATA_W-1:0]    win_mask_s;
  logic [DATA_W-1:0]    merged_s;

  logic [NUM_REQ-1:0]   gnt_next_s;
  logic                 busy_next_s;
  logic [DATA_W-1:0]    shadow_next_s;
  logic                 cs_next_s;
  logic                 write_n_next_s;
  logic [PIO_BUS_W-1:0] writedata_next_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req        (req),
    .ptr        (rr_ptr_r),
    .winner     (win_oh_s),
    .winner_idx (win_idx_s)
  );

  // Only one data register exists on the PIO, so the address is fixed.
  assign pio_address = PIO_DATA_ADDR;

  // Merge the winner's owned bits into the current shadow value.
  always_comb begin
    win_data_s = req_data[win_idx_s*DATA_W +: DATA_W];
    win_mask_s = req_mask[win_idx_s*DATA_W +: DATA_W];
    merged_s   = (led_shadow & ~win_mask_s) | (win_data_s & win_mask_s);
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_next_s     = state_r;
    rr_ptr_next_s    = rr_ptr_r;
    grant_idx_next_s = grant_idx_r;
    grant_oh_next_s  = grant_oh_r;
    gnt_next_s       = {NUM_REQ{1'b0}};
    busy_next_s      = 1'b0;
    shadow_next_s    = led_shadow;
    cs_next_s        = 1'b0;
    write_n_next_s   = 1'b1;
    writedata_next_s = pio_writedata;
    case (state_r)
      INIT: begin
        // Busy stays high through the init write cycle itself.
        state_next_s     = IDLE;
        busy_next_s      = 1'b1;
        cs_next_s        = 1'b1;
        write_n_next_s   = 1'b0;
        writedata_next_s = PIO_BUS_W'(INIT_PATTERN);
        shadow_next_s    = INIT_PATTERN;
      end
      IDLE: begin
        if (|req) begin
          // Grant index and merged value are captured here, so requesters
          // may change their data/mask once the grant is seen.
          state_next_s     = WRITE;
          busy_next_s      = 1'b1;
          grant_idx_next_s = win_idx_s;
          grant_oh_next_s  = win_oh_s;
          cs_next_s        = 1'b1;
          write_n_next_s   = 1'b0;
          writedata_next_s = PIO_BUS_W'(merged_s);
          shadow_next_s    = merged_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        state_next_s  = ACK;
        busy_next_s   = 1'b1;
        gnt_next_s    = grant_oh_r;
        rr_ptr_next_s = (grant_idx_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                            : grant_idx_r + IDX_W'(1);
      end
      ACK: begin
        // Requests are ignored here; the requester drops req during this cycle.
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = INIT;
        busy_next_s  = 1'b1;
      end
    endcase
  end

  // State, arbitration pointer and latched grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= INIT;
      rr_ptr_r    <= {IDX_W{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
      grant_oh_r  <= {NUM_REQ{1'b0}};
    end else begin
      state_r     <= state_next_s;
      rr_ptr_r    <= rr_ptr_next_s;
      grant_idx_r <= grant_idx_next_s;
      grant_oh_r  <= grant_oh_next_s;
    end
  end

  // Registered outputs; reset drops the bus strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt            <= {NUM_REQ{1'b0}};
      busy           <= 1'b1;
      led_shadow     <= {DATA_W{1'b0}};
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= {PIO_BUS_W{1'b0}};
    end else begin
      gnt            <= gnt_next_s;
      busy           <= busy_next_s;
      led_shadow     <= shadow_next_s;
      pio_chipselect <= cs_next_s;
      pio_write_n    <= write_n_next_s;
      pio_writedata  <= writedata_next_s;
    end
  end

endmodule
